// File: rtl/maxpool_stage.sv
// Streaming 2x2 max-pool with threshold activation. Consumes raster-order
// feature values and emits one pooled value per window with valid/ready.
module maxpool_stage #(
    parameter int         IMG_W  = 8,
    parameter int         IMG_H  = 8,
    parameter logic [7:0] THRESH = 8'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_eol,
    output logic       out_eof
);

    localparam int CW  = $clog2(IMG_W);
    localparam int RW  = $clog2(IMG_H);
    localparam int LBW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;

    logic [CW-1:0]  r_col;
    logic [RW-1:0]  r_row;
    logic [7:0]     r_hold;
    logic [7:0]     r_linebuf [IMG_W/2];

    logic           w_accept;
    logic [CW-1:0]  w_col;
    logic [RW-1:0]  w_row;
    logic [LBW-1:0] w_lbIdx;
    logic           w_lastCol;
    logic           w_lastRow;
    logic           w_window;
    logic [7:0]     w_pairMax;
    logic [7:0]     w_winMax;
    logic [8:0]     w_diff;
    logic [7:0]     w_result;

    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    assign in_ready  = !out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;

    // A start-of-frame beat overrides whatever position the counters hold.
    assign w_col     = in_sof ? '0 : r_col;
    assign w_row     = in_sof ? '0 : r_row;
    assign w_lbIdx   = LBW'(w_col >> 1);
    assign w_lastCol = (w_col == CW'(IMG_W - 1));
    assign w_lastRow = (w_row == RW'(IMG_H - 1));
    assign w_window  = w_accept && w_row[0] && w_col[0];

    assign w_pairMax = max8(r_hold, in_data);
    assign w_winMax  = max8(w_pairMax, r_linebuf[w_lbIdx]);
    // Borrow out of the 9-bit subtraction means the pooled value is below threshold.
    assign w_diff    = {1'b0, w_winMax} - {1'b0, THRESH};
    assign w_result  = w_diff[8] ? 8'd0 : w_winMax;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_hold    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_eol   <= 1'b0;
            out_eof   <= 1'b0;
        end else begin
            if (w_accept) begin
                if (!w_col[0]) begin
                    r_hold <= in_data;
                end
                if (w_lastCol) begin
                    r_col <= '0;
                    r_row <= w_lastRow ? '0 : w_row + RW'(1);
                end else begin
                    r_col <= w_col + CW'(1);
                    r_row <= w_row;
                end
            end
            if (w_window) begin
                out_valid <= 1'b1;
                out_data  <= w_result;
                out_eol   <= w_lastCol;
                out_eof   <= w_lastCol && w_lastRow;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // The line buffer carries top-row pair maxima and needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept && !w_row[0] && w_col[0]) begin
            r_linebuf[w_lbIdx] <= w_pairMax;
        end
    end

endmodule

// File: tb/tb_maxpool_stage.sv
// Scoreboard bench for maxpool_stage: two instances (threshold 0 and 8) share
// one input stream; a frame-buffer model predicts each pooled result.
module tb_maxpool_stage;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       inValid;
    logic       inSof;
    logic [7:0] inData;
    logic       outReady;

    logic       inReady0, inReady1;
    logic       outValid0, outValid1;
    logic [7:0] outData0, outData1;
    logic       outEol0, outEol1, outEof0, outEof1;

    typedef struct packed {
        logic [7:0] data;
        logic       eol;
        logic       eof;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    int testsRun    = 0;
    int testsFailed = 0;
    int xfers       = 0;
    int stallArm    = 0;
    int stallLeft   = 0;
    int mCol        = 0;
    int mRow        = 0;
    logic [7:0] px [H][W];

    always #5 clk = ~clk;

    maxpool_stage #(.IMG_W(W), .IMG_H(H), .THRESH(8'd0)) dut0 (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady0), .in_data(inData), .in_sof(inSof),
        .out_valid(outValid0), .out_ready(outReady), .out_data(outData0),
        .out_eol(outEol0), .out_eof(outEof0)
    );

    maxpool_stage #(.IMG_W(W), .IMG_H(H), .THRESH(8'd8)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(inValid), .in_ready(inReady1), .in_data(inData), .in_sof(inSof),
        .out_valid(outValid1), .out_ready(outReady), .out_data(outData1),
        .out_eol(outEol1), .out_eof(outEof1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference: store the frame and, on each window corner, take the max of its four pixels.
    function automatic void modelAccept(input logic [7:0] d, input logic sof);
        logic [7:0] m;
        exp_t e;
        if (sof) begin
            mCol = 0;
            mRow = 0;
        end
        px[mRow][mCol] = d;
        if ((mRow % 2 == 1) && (mCol % 2 == 1)) begin
            m = px[mRow-1][mCol-1];
            if (px[mRow-1][mCol] > m) m = px[mRow-1][mCol];
            if (px[mRow][mCol-1] > m) m = px[mRow][mCol-1];
            if (px[mRow][mCol] > m)   m = px[mRow][mCol];
            e.eol  = (mCol == W - 1);
            e.eof  = (mCol == W - 1) && (mRow == H - 1);
            e.data = m;
            q0.push_back(e);
            e.data = (m < 8'd8) ? 8'd0 : m;
            q1.push_back(e);
        end
        if (mCol == W - 1) begin
            mCol = 0;
            mRow = (mRow == H - 1) ? 0 : mRow + 1;
        end else begin
            mCol++;
        end
    endfunction

    task automatic updateReady();
        if (stallLeft > 0) begin
            outReady = 1'b0;
            stallLeft--;
        end else begin
            outReady = 1'b1;
        end
        if (stallArm != 0 && outValid0) begin
            stallArm  = 0;
            outReady  = 1'b0;
            stallLeft = 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            updateReady();
        end
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic sof);
        int  tries = 0;
        bit  done  = 0;
        inValid = 1'b1;
        inData  = d;
        inSof   = sof;
        while (!done) begin
            @(negedge clk);
            if (inReady0) begin
                modelAccept(d, sof);
                done = 1;
            end else if (++tries > 50) begin
                checkOutput("acceptTimeout", inReady0, 1);
                done = 1;
            end
            @(posedge clk);
            #1;
            updateReady();
        end
        inValid = 1'b0;
        inSof   = 1'b0;
    endtask

    task automatic sendFrame(input logic [7:0] base, input logic [7:0] step, input bit sof, input int count);
        for (int i = 0; i < count; i++) begin
            applyStimulus(base + 8'(i) * step, sof && (i == 0));
        end
    endtask

    task automatic endScenario(input string tag, input int expXfers);
        idle(6);
        checkOutput({tag, "_xfers"}, xfers, expXfers);
        checkOutput({tag, "_q0Empty"}, q0.size(), 0);
        checkOutput({tag, "_q1Empty"}, q1.size(), 0);
        xfers = 0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid0"}, outValid0, 0);
        checkOutput({tag, "_valid1"}, outValid1, 0);
        checkOutput({tag, "_data0"}, outData0, 0);
        checkOutput({tag, "_eol0"}, outEol0, 0);
        checkOutput({tag, "_eof0"}, outEof0, 0);
    endtask

    // Output monitor: compare the head of each scoreboard while valid, pop on transfer.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("inReady", inReady0, !outValid0 || outReady);
            if (outValid0) begin
                if (q0.size() == 0) begin
                    checkOutput("unexpectedOut0", outValid0, 0);
                end else begin
                    e0 = q0[0];
                    checkOutput("data0", outData0, e0.data);
                    checkOutput("eol0", outEol0, e0.eol);
                    checkOutput("eof0", outEof0, e0.eof);
                    if (outReady) begin
                        void'(q0.pop_front());
                        xfers++;
                    end
                end
            end
            if (outValid1) begin
                if (q1.size() == 0) begin
                    checkOutput("unexpectedOut1", outValid1, 0);
                end else begin
                    e1 = q1[0];
                    checkOutput("data1", outData1, e1.data);
                    checkOutput("eol1", outEol1, e1.eol);
                    checkOutput("eof1", outEof1, e1.eof);
                    if (outReady) void'(q1.pop_front());
                end
            end
        end
    end

    initial begin
        rst      = 1'b1;
        inValid  = 1'b0;
        inSof    = 1'b0;
        inData   = 8'd0;
        outReady = 1'b1;
        #12;
        checkResetState("reset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp frame, both thresholds checked concurrently.
        sendFrame(8'd0, 8'd1, 1'b1, 16);
        endScenario("ramp", 4);

        // Downstream stalls for three cycles after the first result.
        stallArm = 1;
        sendFrame(8'd0, 8'd1, 1'b1, 16);
        endScenario("stall", 4);

        // Aborted frame followed by a fresh frame marked with sof.
        sendFrame(8'd0, 8'd1, 1'b1, 6);
        sendFrame(8'd100, 8'd1, 1'b1, 16);
        endScenario("abort", 5);

        // Reset at row 1, col 2, then a frame without sof.
        sendFrame(8'd0, 8'd1, 1'b1, 6);
        rst = 1'b1;
        q0.delete();
        q1.delete();
        mCol = 0;
        mRow = 0;
        #1;
        checkResetState("midReset");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        updateReady();
        sendFrame(8'd0, 8'd1, 1'b0, 16);
        endScenario("afterReset", 4);

        // Saturated frame then zero frame, back to back.
        sendFrame(8'd255, 8'd0, 1'b1, 16);
        sendFrame(8'd0, 8'd0, 1'b1, 16);
        endScenario("extremes", 8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
